mcm3_shift_add_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed shift-add triple-constant multiplier.
- Multiplies one unsigned input sample by three compile-time constants, using only shifts and adds.
- Two-stage pipeline with valid/ready handshakes on both sides.
- Sits in datapaths that need several fixed gains of one sample per cycle, such as filter taps and scaling banks.

---
 rtl/mcm3_shift_add_pipe.sv | 114 +++++++++++
 tb/tb_mcm3_shift_add_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mcm3_shift_add_pipe.sv
// Two-stage shift-add multiplier of one unsigned sample by three constants, valid/ready on both sides.
// Optional macro MCM_SATURATE_EN: clamp each overflowing channel to all ones instead of wrapping.
module mcm3_shift_add_pipe #(
    parameter int          W  = 32,
    parameter int          OW = 32,
    parameter int          CW = 8,
    parameter int unsigned C0 = 13,
    parameter int unsigned C1 = 25,
    parameter int unsigned C2 = 63
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  x,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] y0,
    output logic [OW-1:0] y1,
    output logic [OW-1:0] y2,
    output logic [2:0]    ovf
);
    localparam int PW   = W + CW;
    localparam int HALF = CW / 2;
    localparam logic [2:0][CW-1:0] CK = {CW'(C2), CW'(C1), CW'(C0)};

    // Sum of shifted copies of xv for the set bits of c in the lower (hi=0) or upper (hi=1) half.
    function automatic logic [PW-1:0] part(input logic [W-1:0] xv, input logic [CW-1:0] c,
                                           input logic hi);
        logic [PW-1:0] acc;
        logic [PW-1:0] xe;
        acc = '0;
        xe  = PW'(xv);
        for (int i = 0; i < CW; i++) begin
            if (c[i] && ((i >= HALF) == hi)) acc = acc + (xe << i);
        end
        return acc;
    endfunction

    logic                 s1_valid_q;
    logic                 out_valid_q;
    logic [2:0][PW-1:0]   lo_q, hi_q, lo_d, hi_d;
    logic [2:0][OW-1:0]   y_q, y_d, wrap;
    logic [2:0]           ovf_q, ovf_d;
    logic                 s1_adv, s2_adv, in_fire;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign in_fire  = in_valid && s1_adv;

    always_comb begin
        lo_d = '0;
        hi_d = '0;
        for (int k = 0; k < 3; k++) begin
            lo_d[k] = part(x, CK[k], 1'b0);
            hi_d[k] = part(x, CK[k], 1'b1);
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_red
        logic [PW-1:0] sum;
        assign sum = lo_q[k] + hi_q[k];
        if (OW >= PW) begin : g_wide
            assign wrap[k]  = OW'(sum);
            assign ovf_d[k] = 1'b0;
        end else begin : g_narrow
            assign wrap[k]  = sum[OW-1:0];
            assign ovf_d[k] = |sum[PW-1:OW];
        end
    end

    always_comb begin
        y_d = wrap;
`ifdef MCM_SATURATE_EN
        for (int k = 0; k < 3; k++) begin
            if (ovf_d[k]) y_d[k] = '1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            lo_q        <= '0;
            hi_q        <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            ovf_q       <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_fire) begin
                    lo_q <= lo_d;
                    hi_q <= hi_d;
                end
            end
            // Output register only moves when the downstream has taken (or never had) the result.
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    y_q   <= y_d;
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign y0        = y_q[0];
    assign y1        = y_q[1];
    assign y2        = y_q[2];
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_mcm3_shift_add_pipe.sv
// Bench: default instance plus a C0=0/C1=255/OW=40 instance sharing the same stimulus.
module tb_mcm3_shift_add_pipe;
`ifdef MCM_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [31:0] x = '0;
    logic        in_ready, out_valid, in_ready2, out_valid2;
    logic [31:0] y0, y1, y2;
    logic [39:0] z0, z1, z2;
    logic [2:0]  ovf, ovf2;

    always #5 clk = ~clk;

    mcm3_shift_add_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .out_valid(out_valid), .out_ready(out_ready), .y0(y0), .y1(y1), .y2(y2), .ovf(ovf));

    mcm3_shift_add_pipe #(.W(32), .OW(40), .CW(8), .C0(0), .C1(255), .C2(63)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .x(x),
        .out_valid(out_valid2), .out_ready(out_ready), .y0(z0), .y1(z1), .y2(z2), .ovf(ovf2));

    int          total = 0, bad = 0, nout = 0;
    logic [31:0] q[$];
    logic        fired = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: plain product, reduced modulo 2^ow (or clamped when saturating).
    function automatic logic [64:0] mdl(input logic [31:0] xv, input int unsigned c, input int ow);
        logic [63:0] p, msk, yv;
        logic        o;
        p   = 64'(xv) * 64'(c);
        msk = (64'd1 << ow) - 64'd1;
        o   = (p & ~msk) != 64'd0;
        yv  = (SAT && o) ? msk : (p & msk);
        return {o, yv};
    endfunction

    int unsigned ca[3] = '{13, 25, 63};
    int unsigned cb[3] = '{0, 255, 63};

    always @(negedge clk) begin
        if (!rst_n) begin
            fired <= 1'b0;
        end else begin
            fired <= in_valid && in_ready;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_extra actual=out_valid required=no_output");
                end else begin
                    automatic logic [31:0] xv = q.pop_front();
                    automatic logic [31:0] ya[3];
                    automatic logic [39:0] za[3];
                    automatic logic [2:0]  oa = '0, ob = '0;
                    automatic logic [64:0] r;
                    ya = '{y0, y1, y2};
                    za = '{z0, z1, z2};
                    for (int k = 0; k < 3; k++) begin
                        r = mdl(xv, ca[k], 32);
                        chk($sformatf("sb_y%0d x=%0h", k, xv), 64'(ya[k]), r[63:0]);
                        oa[k] = r[64];
                        r = mdl(xv, cb[k], 40);
                        chk($sformatf("sb2_y%0d x=%0h", k, xv), 64'(za[k]), r[63:0]);
                        ob[k] = r[64];
                    end
                    chk("sb_ovf", 64'(ovf), 64'(oa));
                    chk("sb2_ovf", 64'(ovf2), 64'(ob));
                    chk("sb2_valid", 64'(out_valid2), 64'd1);
                    nout++;
                end
            end
            if (in_valid && in_ready) q.push_back(x);
        end
    end

    task automatic drive(input logic [31:0] v);
        bit ok = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        x        = v;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL drive_timeout actual=in_ready_low required=accept");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [31:0] x;
        logic [31:0] y0, y1, y2;
        logic [2:0]  ov;
        logic [39:0] z0, z1, z2;
        logic [2:0]  ov2;
    } vec_t;
    vec_t tv[5];

    initial begin
        int n0;
        tv[0] = '{32'd1, 32'd13, 32'd25, 32'd63, 3'b000, 40'd0, 40'd255, 40'd63, 3'b000};
        tv[1] = '{32'hFFFF_FFFF,
                  SAT ? 32'hFFFF_FFFF : 32'hFFFF_FFF3,
                  SAT ? 32'hFFFF_FFFF : 32'hFFFF_FFE7,
                  SAT ? 32'hFFFF_FFFF : 32'hFFFF_FFC1, 3'b111,
                  40'd0, 40'hFE_FFFF_FF01, 40'h3E_FFFF_FFC1, 3'b000};
        tv[2] = '{32'd0, 32'd0, 32'd0, 32'd0, 3'b000, 40'd0, 40'd0, 40'd0, 3'b000};
        tv[3] = '{32'h0400_0000, 32'h3400_0000, 32'h6400_0000, 32'hFC00_0000, 3'b000,
                  40'd0, 40'h3_FC00_0000, 40'h0_FC00_0000, 3'b000};
        tv[4] = '{32'h0800_0000, 32'h6800_0000, 32'hC800_0000,
                  SAT ? 32'hFFFF_FFFF : 32'hF800_0000, 3'b100,
                  40'd0, 40'h7_F800_0000, 40'h1_F800_0000, 3'b000};

        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_y0", 64'(y0), 64'd0);
        chk("rst_y1", 64'(y1), 64'd0);
        chk("rst_y2", 64'(y2), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed vectors with latency check: nothing after the accept edge, result after the next.
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b1;
            drive(tv[i].x);
            chk($sformatf("lat_early[%0d]", i), 64'(out_valid), 64'd0);
            @(posedge clk); #1;
            chk($sformatf("lat_valid[%0d]", i), 64'(out_valid), 64'd1);
            chk($sformatf("tv_y0[%0d]", i), 64'(y0), 64'(tv[i].y0));
            chk($sformatf("tv_y1[%0d]", i), 64'(y1), 64'(tv[i].y1));
            chk($sformatf("tv_y2[%0d]", i), 64'(y2), 64'(tv[i].y2));
            chk($sformatf("tv_ovf[%0d]", i), 64'(ovf), 64'(tv[i].ov));
            chk($sformatf("tv2_y0[%0d]", i), 64'(z0), 64'(tv[i].z0));
            chk($sformatf("tv2_y1[%0d]", i), 64'(z1), 64'(tv[i].z1));
            chk($sformatf("tv2_y2[%0d]", i), 64'(z2), 64'(tv[i].z2));
            chk($sformatf("tv2_ovf[%0d]", i), 64'(ovf2), 64'(tv[i].ov2));
            repeat (2) @(posedge clk);
        end

        // Back-to-back stream.
        n0 = nout;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            x        = i;
            @(negedge clk);
            chk($sformatf("stream_rdy[%0d]", i), 64'(in_ready), 64'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("stream_count", 64'(nout - n0), 64'd10);

        // Backpressure: fill both stages, hold, then drain.
        n0 = nout;
        out_ready = 1'b0;
        @(posedge clk); #1; in_valid = 1'b1; x = 32'd2;
        @(posedge clk); #1; x = 32'd3;
        @(posedge clk); #1; x = 32'd4;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_hold_y0[%0d]", i), 64'(y0), 64'd26);
            chk($sformatf("bp_full_rdy[%0d]", i), 64'(in_ready), 64'd0);
            chk($sformatf("bp_valid[%0d]", i), 64'(out_valid), 64'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("bp_count", 64'(nout - n0), 64'd3);

        // Reset with two samples in flight.
        out_ready = 1'b0;
        @(posedge clk); #1; in_valid = 1'b1; x = 32'd7;
        @(posedge clk); #1; x = 32'd8;
        @(posedge clk); #1; in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_y0", 64'(y0), 64'd0);
        chk("mid_rst_ovf", 64'(ovf), 64'd0);
        chk("mid_rst_rdy", 64'(in_ready), 64'd1);
        q.delete();
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n0 = nout;
        repeat (3) @(posedge clk);
        #1 chk("post_rst_quiet", 64'(nout - n0), 64'd0);
        drive(32'd5);
        @(posedge clk); #1;
        chk("post_rst_y0", 64'(y0), 64'd65);
        chk("post_rst_y1", 64'(y1), 64'd125);
        chk("post_rst_y2", 64'(y2), 64'd315);
        repeat (4) @(posedge clk);
        #1 chk("post_rst_count", 64'(nout - n0), 64'd1);

        // Random traffic with random backpressure; source holds x until accepted.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            if (!in_valid || fired) begin
                in_valid = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 3))
                    0:       x = $urandom_range(0, 15);
                    1:       x = 32'hFFFF_FFFF - $urandom_range(0, 15);
                    default: x = $urandom;
                endcase
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("rand_drained", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
